// File: rtl/mem_read_streamer_pkg.sv
// Shared defaults and FSM encoding for the memory read streamer.
package mem_read_streamer_pkg;
   localparam int WORD_SIZE_DEF  = 16;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 256;
   localparam int RD_LAT_DEF     = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/mem_read_streamer_stream_fifo.sv
// Small circular FIFO used as the output buffer; head is visible combinationally.
module stream_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clka,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/mem_read_streamer.sv
// Streams DEPTH words out of a fixed-latency RAM onto a valid/ready port,
// issuing reads only when buffer space is guaranteed, and sums accepted words.
module mem_read_streamer
   import mem_read_streamer_pkg::*;
#(
   parameter int WORD_SIZE  = WORD_SIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int RD_LAT     = RD_LAT_DEF
) (
   input  logic                            clka,
   input  logic                            rst,
   input  logic                            start,
   output logic [ADDR_WIDTH-1:0]           addra,
   output logic                            ena,
   input  logic [WORD_SIZE-1:0]            douta,
   output logic [WORD_SIZE-1:0]            m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_last,
   output logic [WORD_SIZE+ADDR_WIDTH-1:0] sum,
   output logic                            busy,
   output logic                            done
);
   localparam int FIFO_DEPTH = RD_LAT + 1;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W      = ADDR_WIDTH + 1;

   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                issue_cnt_q, issue_cnt_d;
   logic [IDX_W-1:0]                out_cnt_q, out_cnt_d;
   logic [RD_LAT-1:0]               dl_q, dl_d;
   logic [RD_LAT:0]                 dl_shift;
   logic [WORD_SIZE+ADDR_WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]                fifo_count, inflight;
   logic [WORD_SIZE-1:0]            fifo_head;
   logic fifo_empty, fifo_push, fifo_pop, cap, accept, credit_ok;
   logic start_run, last_issue, last_accept;

   stream_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clka    (clka),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (douta),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(dl_q[i]);
   end

   // Read-capture word cuts through when the buffer is empty, so the
   // buffer only holds words the consumer has not yet taken.
   assign cap         = dl_q[RD_LAT-1];
   assign credit_ok   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
   assign m_valid     = !fifo_empty || cap;
   assign m_data      = !fifo_empty ? fifo_head : (cap ? douta : '0);
   assign accept      = m_valid && m_ready;
   assign fifo_push   = cap && !(fifo_empty && m_ready);
   assign fifo_pop    = !fifo_empty && m_ready;
   assign m_last      = m_valid && (out_cnt_q == IDX_W'(DEPTH - 1));
   assign last_accept = accept && m_last;
   assign start_run   = (state_q == ST_IDLE) && start;
   assign last_issue  = ena && (issue_cnt_q == IDX_W'(DEPTH - 1));
   assign addra       = issue_cnt_q[ADDR_WIDTH-1:0];
   assign sum         = sum_q;
   assign dl_shift    = {dl_q, ena};
   assign dl_d        = dl_shift[RD_LAT-1:0];

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         out_cnt_q   <= '0;
         dl_q        <= '0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         out_cnt_q   <= out_cnt_d;
         dl_q        <= dl_d;
         sum_q       <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)       state_d = ST_READ;
         ST_READ:  if (last_issue)  state_d = ST_DRAIN;
         ST_DRAIN: if (last_accept) state_d = ST_DONE;
         ST_DONE:                   state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ena  = (state_q == ST_READ) && credit_ok;
      busy = (state_q == ST_READ) || (state_q == ST_DRAIN);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      out_cnt_d   = out_cnt_q;
      sum_d       = sum_q;
      if (start_run) begin
         issue_cnt_d = '0;
         out_cnt_d   = '0;
         sum_d       = '0;
      end else begin
         if (ena) issue_cnt_d = issue_cnt_q + 1'b1;
         if (accept) begin
            out_cnt_d = out_cnt_q + 1'b1;
            sum_d     = sum_q + {{ADDR_WIDTH{1'b0}}, m_data};
         end
      end
   end
endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench: each run queues the expected word stream, a negedge monitor checks it.
module tb_mem_read_streamer;
   localparam int N = 256;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   logic        clka = 0;
   logic        rst = 0;
   logic        start = 0;
   logic [7:0]  addra;
   logic        ena;
   logic [15:0] douta = '0;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1;
   logic        m_last;
   logic [23:0] sum;
   logic        busy;
   logic        done;

   logic [15:0] mem [N];
   exp_t        exp_q [$];
   int tests = 0, fails = 0;
   int cyc = 0, start_cyc = 0, ready_mode = 0;
   int exp_addr, issued, accepted, done_cnt, done_cyc, first_ena, first_valid;

   mem_read_streamer dut (
      .clka(clka), .rst(rst), .start(start), .addra(addra), .ena(ena),
      .douta(douta), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .sum(sum), .busy(busy), .done(done)
   );

   always #5 clka = ~clka;
   always @(posedge clka) if (ena) douta <= mem[addra];
   initial forever begin @(posedge clka); cyc = cyc + 1; end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clka); #1;
      case (ready_mode)
         1:       m_ready = ~m_ready;
         2:       m_ready = ((cyc - start_cyc) >= 20);
         default: m_ready = 1'b1;
      endcase
   end

   // Monitor: address sequence, hold-while-stalled, credit bound, scoreboard.
   initial begin
      bit          stalled_prev;
      logic [15:0] prev_data;
      int          rel;
      exp_t        e;
      stalled_prev = 0;
      prev_data    = '0;
      forever begin
         @(negedge clka);
         if (!rst) begin
            stalled_prev = 0;
         end else begin
            rel = cyc - start_cyc;
            if (ena) begin
               check("addra", addra, exp_addr);
               if (first_ena < 0) first_ena = rel;
               exp_addr++;
               issued++;
            end
            if (m_valid && first_valid < 0) first_valid = rel;
            if (stalled_prev) check("hold", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL extra_word: got %0h expected none", m_data);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", m_data, e.d);
                  check("m_last", m_last, e.l);
               end
               accepted++;
            end
            check("outstanding_le2", (issued - accepted) <= 2, 1);
            if (done) begin done_cnt++; done_cyc = rel; end
            stalled_prev = m_valid && !m_ready;
            prev_data    = m_data;
         end
      end
   end

   task automatic run(input int mode, input int restart_at, input int reset_at,
                      input logic [23:0] exp_sum);
      int rel;
      bit aborted;
      aborted = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back({mem[i], (i == N - 1)});
      exp_addr = 0; issued = 0; accepted = 0; done_cnt = 0;
      done_cyc = -1; first_ena = -1; first_valid = -1;
      ready_mode = mode;
      @(posedge clka); #1;
      start = 1;
      start_cyc = cyc;
      for (int k = 0; k < 3000 && done_cnt == 0 && !aborted; k++) begin
         @(posedge clka); #1;
         rel = cyc - start_cyc;
         start = (rel == restart_at);
         if (rel == 1) begin
            check("sum_cleared", sum, 0);
            check("busy_run", busy, 1);
         end
         if (mode == 2 && rel == 19) begin
            check("stall_reads", issued, 2);
            check("stall_ena", ena, 0);
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, 0);
         end
         if (rel == reset_at) begin
            rst = 0;
            #1;
            check("abort_outputs", {addra, ena, m_valid, m_data, m_last, busy, done}, 0);
            check("abort_sum", sum, 0);
            @(posedge clka); #1;
            rst = 1;
            for (int j = 0; j < 5; j++) begin
               @(posedge clka); #1;
               check("idle_after_abort", {ena, busy, done, m_valid}, 0);
            end
            aborted = 1;
         end
      end
      if (aborted) begin
         exp_q.delete();
      end else if (done_cnt == 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end else begin
         repeat (3) @(posedge clka);
         #1;
         check("done_single", done_cnt, 1);
         check("busy_after", busy, 0);
         check("sum_final", sum, exp_sum);
         check("accepted", accepted, N);
         check("queue_empty", exp_q.size(), 0);
         if (mode == 0) begin
            check("first_ena_cyc", first_ena, 1);
            check("first_valid_cyc", first_valid, 2);
            check("done_cyc", done_cyc, 258);
         end
      end
      $display("[TB] run mode=%0d restart=%0d reset=%0d done_cyc=%0d sum=%0h", mode, restart_at, reset_at, done_cyc, sum);
   endtask

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 16'(i);
      repeat (3) @(posedge clka);
      #1;
      check("reset_outputs", {addra, ena, m_valid, m_data, m_last, busy, done}, 0);
      check("reset_sum", sum, 0);
      rst = 1;
      run(0, -1, -1, 24'd32640);
      run(1, -1, -1, 24'd32640);
      run(2, -1, -1, 24'd32640);
      for (int i = 0; i < N; i++) mem[i] = 16'hFFFF;
      run(0, -1, -1, 24'hFFFF00);
      for (int i = 0; i < N; i++) mem[i] = 16'(i);
      run(0, 50, -1, 24'd32640);
      run(0, -1, 100, 24'd0);
      run(0, -1, -1, 24'd32640);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
